// File: rtl/ndma_xfer_ctrl.sv
// NanoDMA transfer sequencer.
// Latches a copy descriptor on a start pulse and moves the data one 32-bit
// word at a time: an OBI read on the read-manager port, then an OBI write of
// the same word on the write-manager port, through a single-word buffer.
// Only one port is ever requesting, and each port has at most one
// transaction outstanding.
module ndma_xfer_ctrl #(
    parameter int unsigned AddrStep = 4,
    parameter int unsigned LenWidth = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    // register block side
    input  logic                start_i,
    input  logic [31:0]         src_addr_i,
    input  logic [31:0]         dst_addr_i,
    input  logic [LenWidth-1:0] len_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [LenWidth-1:0] words_done_o,
    // read-manager OBI port
    output logic                rd_req_o,
    input  logic                rd_gnt_i,
    output logic [31:0]         rd_addr_o,
    input  logic                rd_rvalid_i,
    input  logic [31:0]         rd_rdata_i,
    // write-manager OBI port
    output logic                wr_req_o,
    input  logic                wr_gnt_i,
    output logic                wr_we_o,
    output logic [3:0]          wr_be_o,
    output logic [31:0]         wr_addr_o,
    output logic [31:0]         wr_wdata_o,
    input  logic                wr_rvalid_i
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         src_q;
    logic [31:0]         dst_q;
    logic [31:0]         buf_q;
    logic [LenWidth-1:0] remaining_q;
    logic [LenWidth-1:0] words_done_q;

    // single-cycle events decoded by the FSM, consumed by the datapath
    logic                accept_start;
    logic                load_desc;
    logic                capture_rdata;
    logic                word_complete;

    // Next-state decode and datapath strobes.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal; a missing
        // assignment in combinational logic would infer a latch.
        state_d       = state_q;
        accept_start  = 1'b0;
        load_desc     = 1'b0;
        capture_rdata = 1'b0;
        word_complete = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    accept_start = 1'b1;
                    if (len_i != '0) begin
                        load_desc = 1'b1;
                        state_d   = RD_REQ;
                    end else begin
                        // empty descriptor: report completion with no bus traffic
                        state_d   = DONE;
                    end
                end
            end
            RD_REQ: begin
                if (rd_gnt_i) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // the response is never taken in the gnt cycle, only here
                if (rd_rvalid_i) begin
                    capture_rdata = 1'b1;
                    state_d       = WR_REQ;
                end
            end
            WR_REQ: begin
                if (wr_gnt_i) begin
                    state_d = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (wr_rvalid_i) begin
                    word_complete = 1'b1;
                    state_d       = (remaining_q == LenWidth'(1)) ? DONE : RD_REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value regardless of statement order.
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Descriptor, holding buffer and progress counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src_q        <= '0;
            dst_q        <= '0;
            buf_q        <= '0;
            remaining_q  <= '0;
            words_done_q <= '0;
        end else begin
            if (accept_start) begin
                words_done_q <= '0;
            end
            if (load_desc) begin
                // word-aligned addresses: the low two bits are dropped
                src_q       <= src_addr_i & 32'hFFFF_FFFC;
                dst_q       <= dst_addr_i & 32'hFFFF_FFFC;
                remaining_q <= len_i;
            end
            if (capture_rdata) begin
                buf_q <= rd_rdata_i;
            end
            if (word_complete) begin
                // addresses wrap silently modulo 2^32
                src_q        <= src_q + 32'(AddrStep);
                dst_q        <= dst_q + 32'(AddrStep);
                remaining_q  <= remaining_q - LenWidth'(1);
                words_done_q <= words_done_q + LenWidth'(1);
            end
        end
    end

    // Outputs are decoded from registered state, so they are glitch-free and
    // hold still while a request waits for its grant.
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    assign words_done_o = words_done_q;

    assign rd_req_o     = (state_q == RD_REQ);
    assign rd_addr_o    = src_q;

    assign wr_req_o     = (state_q == WR_REQ);
    assign wr_we_o      = 1'b1;
    assign wr_be_o      = 4'hF;
    assign wr_addr_o    = dst_q;
    assign wr_wdata_o   = buf_q;

endmodule
